// File: rtl/prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: port groupings, control
// register record and the compressed-instruction test.
package prefetch_queue_pkg;

    // Address-width fields (npc, fpc) stay outside the structs so AW can vary.
    typedef struct packed {
        logic        jump;
        logic        fence;
        logic        take;
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } prefetch_queue_in_type;

    typedef struct packed {
        logic [31:0] instr;
        logic        stall;
        logic        mem_valid;
    } prefetch_queue_out_type;

    typedef struct packed {
        logic busy;
        logic drop;
        logic skip;
    } prefetch_queue_reg_type;

    localparam prefetch_queue_reg_type init_prefetch_queue_reg = '{
        busy: 1'b0,
        drop: 1'b0,
        skip: 1'b0
    };

    function automatic logic is_rvc(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/prefetch_queue_ram.sv
// Halfword circular buffer storage: one write port storing one or two
// consecutive halfwords, two combinational read ports at ra and ra+1.
module prefetch_queue_ram #(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          we2,
    input  logic [PW-1:0] wa,
    input  logic [31:0]   wd,
    input  logic [PW-1:0] ra,
    output logic [15:0]   rd0,
    output logic [15:0]   rd1
);

    logic [DEPTH-1:0][15:0] mem;
    logic [PW-1:0]          wa1;
    logic [PW-1:0]          ra1;

    assign wa1 = wa + PW'(1);
    assign ra1 = ra + PW'(1);
    assign rd0 = mem[ra];
    assign rd1 = mem[ra1];

    // Single-halfword writes carry the upper half of a word entered mid-word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (we) begin
            if (we2) begin
                mem[wa]  <= wd[15:0];
                mem[wa1] <= wd[31:16];
            end else begin
                mem[wa]  <= wd[31:16];
            end
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches aligned words ahead of the fetch PC,
// buffers them as halfwords and presents the next 16- or 32-bit instruction.
module prefetch_queue #(
    parameter int            DEPTH    = 8,
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump,
    input  logic          fence,
    input  logic [AW-1:0] npc,
    input  logic          take,
    output logic [31:0]   instr,
    output logic          stall,
    output logic [AW-1:0] fpc,
    output logic          mem_valid,
    input  logic          mem_ready,
    input  logic [31:0]   mem_rdata
);

    import prefetch_queue_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    prefetch_queue_in_type  in_s;
    prefetch_queue_out_type out_s;
    prefetch_queue_reg_type r, r_nxt;

    logic [PW-1:0] wp, rp;
    logic [CW-1:0] count, count_nxt;
    logic [AW-1:0] fpc_q;
    logic [15:0]   h0, h1;
    logic          flush, resp, accept, rvc, complete, pop, issue;
    logic [1:0]    wr_n, pop_n;
    logic          npc_unused;

    assign in_s = '{jump: jump, fence: fence, take: take,
                    mem_ready: mem_ready, mem_rdata: mem_rdata};
    assign instr      = out_s.instr;
    assign stall      = out_s.stall;
    assign mem_valid  = out_s.mem_valid;
    assign npc_unused = npc[0];

    prefetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (accept),
        .we2 (~r.skip),
        .wa  (wp),
        .wd  (in_s.mem_rdata),
        .ra  (rp),
        .rd0 (h0),
        .rd1 (h1)
    );

    always_comb begin
        flush     = in_s.jump | in_s.fence;
        resp      = in_s.mem_ready & r.busy;
        accept    = resp & ~r.drop & ~flush;
        rvc       = is_rvc(h0);
        complete  = rvc ? (count >= CW'(1)) : (count >= CW'(2));
        pop       = in_s.take & complete & ~flush;
        pop_n     = pop ? (rvc ? 2'd1 : 2'd2) : 2'd0;
        wr_n      = accept ? (r.skip ? 2'd1 : 2'd2) : 2'd0;
        count_nxt = flush ? '0 : count + CW'(wr_n) - CW'(pop_n);
        // Space is judged on the post-write, post-pop fill so a back-to-back
        // request can never land a word the buffer cannot hold.
        issue     = rst & ~flush & ~(r.busy & ~in_s.mem_ready)
                  & (count_nxt <= CW'(DEPTH - 2));

        out_s.stall     = ~complete;
        out_s.mem_valid = issue;
        out_s.instr     = '0;
        if (complete)
            out_s.instr = rvc ? {16'h0, h0} : {h1, h0};
    end

    // The request address already points past a word completing this cycle.
    assign fpc = accept ? fpc_q + AW'(4) : fpc_q;

    always_comb begin
        r_nxt      = r;
        r_nxt.busy = issue | (r.busy & ~in_s.mem_ready);
        if (flush) begin
            r_nxt.drop = r.busy & ~in_s.mem_ready;
            r_nxt.skip = npc[1];
        end else begin
            if (resp)
                r_nxt.drop = 1'b0;
            if (accept)
                r_nxt.skip = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r     <= init_prefetch_queue_reg;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            fpc_q <= {RESET_PC[AW-1:2], 2'b00};
        end else begin
            r     <= r_nxt;
            count <= count_nxt;
            if (flush) begin
                wp    <= '0;
                rp    <= '0;
                fpc_q <= {npc[AW-1:2], 2'b00};
            end else begin
                wp <= wp + PW'(wr_n);
                rp <= rp + PW'(pop_n);
                if (accept)
                    fpc_q <= fpc_q + AW'(4);
            end
        end
    end

    count_in_range: assert property (@(posedge clk) disable iff (!rst)
        count <= CW'(DEPTH));

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed latency/flush/full/reset checks plus a
// randomized run compared against a program-order instruction stream model.
module tb_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump = 1'b0, fence = 1'b0, take = 1'b0;
    logic [31:0] npc = '0;
    logic [31:0] instr;
    logic        stall;
    logic [31:0] fpc;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    // memory responder state
    bit          pend;
    logic [31:0] paddr;
    int          pcnt;
    int          lat_min = 1, lat_max = 1;
    logic [31:0] dmem [logic [31:0]];

    logic        s_mv, s_stall;
    logic [31:0] s_fpc, s_instr;

    always #5 clk = ~clk;

    prefetch_queue #(.DEPTH(4), .AW(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .jump      (jump),
        .fence     (fence),
        .npc       (npc),
        .take      (take),
        .instr     (instr),
        .stall     (stall),
        .fpc       (fpc),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] x;
        if (dmem.exists(a)) return dmem[a];
        x = a * 32'h9E37_79B1 + 32'h1234_5677;
        x = x ^ (x >> 15);
        return (x * 32'h85EB_CA6B) ^ (x >> 13);
    endfunction

    function automatic logic [15:0] hw(input logic [31:0] pc);
        logic [31:0] w;
        w = memword({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // Instruction found at pc in program order.
    function automatic logic [31:0] ref_instr(input logic [31:0] pc);
        logic [15:0] h;
        h = hw(pc);
        if (h[1:0] != 2'b11) return {16'h0, h};
        return {hw(pc + 32'd2), h};
    endfunction

    // One clock: starts and ends at a falling edge; caller sets inputs first.
    task automatic step();
        if (pend && pcnt == 1) begin
            mem_ready = 1'b1;
            mem_rdata = memword(paddr);
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end
        #1;
        s_mv = mem_valid; s_fpc = fpc; s_stall = stall; s_instr = instr;
        chk("one_outstanding", 32'(s_mv && pend && !mem_ready), 32'd0);
        @(posedge clk);
        if (mem_ready) pend = 1'b0;
        else if (pend) pcnt--;
        if (s_mv) begin
            pend  = 1'b1;
            paddr = s_fpc;
            pcnt  = int'($urandom_range(lat_max, lat_min));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; jump = 1'b0; fence = 1'b0; take = 1'b0; npc = '0;
        mem_ready = 1'b0; mem_rdata = '0; pend = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int          k, n, run;
        logic [31:0] mpc;
        logic [31:0] exp_list [6];

        // ---- reset values
        @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_fpc", fpc, 32'h0);

        // ---- startup latency and instruction stream incl. compressed pair and straddle
        dmem[32'h00] = 32'h0000_0013;
        dmem[32'h04] = 32'h0041_0093;
        dmem[32'h08] = 32'h0001_0001;
        dmem[32'h0C] = 32'h0093_0001;
        dmem[32'h10] = 32'h0000_0041;
        exp_list = '{32'h13, 32'h0041_0093, 32'h1, 32'h1, 32'h1, 32'h0041_0093};
        do_reset();
        step();
        chk("c1_mem_valid", 32'(s_mv), 32'd1);
        chk("c1_fpc", s_fpc, 32'h0);
        step();
        chk("c2_mem_valid", 32'(s_mv), 32'd1);
        chk("c2_fpc", s_fpc, 32'h4);
        chk("c3_stall", 32'(stall), 32'd0);
        chk("c3_instr", instr, 32'h13);
        take = 1'b1;
        k = 0; mpc = '0;
        for (int i = 0; i < 40 && k < 6; i++) begin
            step();
            if (i == 0) chk("c3_fpc", s_fpc, 32'h8);
            if (!s_stall) begin
                chk("stream_const", s_instr, exp_list[k]);
                chk("stream_model", s_instr, ref_instr(mpc));
                mpc += (s_instr[1:0] != 2'b11) ? 32'd2 : 32'd4;
                k++;
            end
        end
        chk("stream_len", k, 32'd6);
        take = 1'b0;

        // ---- full queue with DEPTH=4, then compressed pops
        dmem[32'h00] = 32'h0001_0001;
        dmem[32'h04] = 32'h0001_0001;
        do_reset();
        step(); chk("full_mv1", 32'(s_mv), 32'd1);
        step(); chk("full_mv2", 32'(s_mv), 32'd1);
        step(); chk("full_mv3", 32'(s_mv), 32'd0);
        chk("full_instr", instr, 32'h1);
        step(); chk("full_mv4", 32'(s_mv), 32'd0);
        take = 1'b1;
        step(); chk("full_pop1_mv", 32'(s_mv), 32'd0);
        step(); chk("full_pop2_mv", 32'(s_mv), 32'd1);
        chk("full_pop2_fpc", s_fpc, 32'h8);
        take = 1'b0;

        // ---- jump with a request outstanding; stale word dropped
        dmem[32'h100] = 32'h4505_1234;
        lat_min = 2; lat_max = 2;
        do_reset();
        step();
        chk("jmp_issue_fpc", s_fpc, 32'h0);
        jump = 1'b1; npc = 32'h102;
        step();
        chk("jmp_flush_mv", 32'(s_mv), 32'd0);
        jump = 1'b0;
        chk("jmp_stall_after", 32'(stall), 32'd1);
        step();
        chk("jmp_refetch_mv", 32'(s_mv), 32'd1);
        chk("jmp_refetch_fpc", s_fpc, 32'h100);
        n = 1;
        while (stall && n < 10) begin
            step();
            n++;
        end
        chk("jmp_latency", n, 32'd3);
        chk("jmp_instr", instr, 32'h0000_4505);

        // ---- asynchronous reset while a response is on the bus
        lat_min = 1; lat_max = 1;
        do_reset();
        step();
        step();
        chk("arst_pre_instr", instr, 32'h1);
        mem_ready = 1'b1;
        mem_rdata = memword(32'h4);
        rst = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'd1);
        chk("arst_instr", instr, 32'h0);
        chk("arst_mv", 32'(mem_valid), 32'd0);
        chk("arst_fpc", fpc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("arst_hold_stall", 32'(stall), 32'd1);
        pend = 1'b0; mem_ready = 1'b0;
        rst = 1'b1;
        step();
        chk("arst_restart_fpc", s_fpc, 32'h0);
        chk("arst_restart_mv", 32'(s_mv), 32'd1);

        // ---- randomized run against the program-order model
        dmem.delete();
        lat_min = 1; lat_max = 3;
        do_reset();
        mpc = '0; run = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            take  = ($urandom_range(9) < 7);
            r     = int'($urandom_range(99));
            jump  = (r < 2);
            fence = (r == 2);
            npc   = $urandom & 32'h0000_3FFF;
            step();
            if (s_stall) chk("rand_stall_instr", s_instr, 32'h0);
            if (!s_stall && take && !(jump || fence)) begin
                chk("rand_instr", s_instr, ref_instr(mpc));
                mpc += (s_instr[1:0] != 2'b11) ? 32'd2 : 32'd4;
            end
            if (jump || fence) begin
                mpc = {npc[31:1], 1'b0};
                run = 0;
            end else if (s_stall) begin
                run++;
            end else begin
                run = 0;
            end
            chk("rand_progress", 32'(run > 16), 32'd0);
        end
        jump = 1'b0; fence = 1'b0; take = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
